// File: rtl/seq_burst_monitor.sv
// Captures one burst of 16-bit samples while `sequencing` is high. On the falling
// edge of `sequencing` it reports length, min, max, sum, first/last and ramp/overrun flags.
module seq_burst_monitor #(
  parameter int MAX_LEN    = 1024,
  parameter bit CHECK_RAMP = 1'b1,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sequencing,
  input  logic [15:0]        smpl_in,
  output logic               busy,
  output logic               burst_done,
  output logic [LEN_W-1:0]   burst_len,
  output logic [15:0]        smpl_min,
  output logic [15:0]        smpl_max,
  output logic [16+LEN_W-1:0] smpl_sum,
  output logic [15:0]        first_smpl,
  output logic [15:0]        last_smpl,
  output logic               ramp_err,
  output logic               overrun
);

  localparam int SUM_W = 16 + LEN_W;

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, REPORT = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        min_q, min_d, max_q, max_d;
  logic [15:0]        first_q, first_d, last_q, last_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               ramp_q, ramp_d, ovr_q, ovr_d;

  logic [LEN_W-1:0]   res_len_q, res_len_d;
  logic [15:0]        res_min_q, res_min_d, res_max_q, res_max_d;
  logic [15:0]        res_first_q, res_first_d, res_last_q, res_last_d;
  logic [SUM_W-1:0]   res_sum_q, res_sum_d;
  logic               res_ramp_q, res_ramp_d, res_ovr_q, res_ovr_d;
  logic               done_q, done_d;

  function automatic logic [15:0] umin(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [15:0] umax(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // A wrap from 0xFFFF to 0x0000 counts as a valid increment.
  function automatic logic ramp_break(input logic [15:0] prev, input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = prev + 16'd1;
    return CHECK_RAMP && (cur != nxt);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    min_d       = min_q;
    max_d       = max_q;
    first_d     = first_q;
    last_d      = last_q;
    sum_d       = sum_q;
    ramp_d      = ramp_q;
    ovr_d       = ovr_q;
    res_len_d   = res_len_q;
    res_min_d   = res_min_q;
    res_max_d   = res_max_q;
    res_first_d = res_first_q;
    res_last_d  = res_last_q;
    res_sum_d   = res_sum_q;
    res_ramp_d  = res_ramp_q;
    res_ovr_d   = res_ovr_q;
    done_d      = 1'b0;

    case (state_q)
      CAPTURE: begin
        if (sequencing) begin
          if (cnt_q < LEN_W'(MAX_LEN)) begin
            cnt_d  = cnt_q + LEN_W'(1);
            min_d  = umin(min_q, smpl_in);
            max_d  = umax(max_q, smpl_in);
            sum_d  = sum_q + SUM_W'(smpl_in);
            last_d = smpl_in;
            if (ramp_break(last_q, smpl_in)) ramp_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          state_d     = REPORT;
          res_len_d   = cnt_q;
          res_min_d   = min_q;
          res_max_d   = max_q;
          res_first_d = first_q;
          res_last_d  = last_q;
          res_sum_d   = sum_q;
          res_ramp_d  = ramp_q;
          res_ovr_d   = ovr_q;
          done_d      = 1'b1;
        end
      end
      default: begin
        // IDLE and REPORT both start a new burst on the first high sample.
        if (sequencing) begin
          state_d = CAPTURE;
          cnt_d   = LEN_W'(1);
          min_d   = smpl_in;
          max_d   = smpl_in;
          first_d = smpl_in;
          last_d  = smpl_in;
          sum_d   = SUM_W'(smpl_in);
          ramp_d  = 1'b0;
          ovr_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      sum_q       <= '0;
      ramp_q      <= 1'b0;
      ovr_q       <= 1'b0;
      res_len_q   <= '0;
      res_min_q   <= '0;
      res_max_q   <= '0;
      res_first_q <= '0;
      res_last_q  <= '0;
      res_sum_q   <= '0;
      res_ramp_q  <= 1'b0;
      res_ovr_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      min_q       <= min_d;
      max_q       <= max_d;
      first_q     <= first_d;
      last_q      <= last_d;
      sum_q       <= sum_d;
      ramp_q      <= ramp_d;
      ovr_q       <= ovr_d;
      res_len_q   <= res_len_d;
      res_min_q   <= res_min_d;
      res_max_q   <= res_max_d;
      res_first_q <= res_first_d;
      res_last_q  <= res_last_d;
      res_sum_q   <= res_sum_d;
      res_ramp_q  <= res_ramp_d;
      res_ovr_q   <= res_ovr_d;
      done_q      <= done_d;
    end
  end

  assign busy       = (state_q == CAPTURE);
  assign burst_done = done_q;
  assign burst_len  = res_len_q;
  assign smpl_min   = res_min_q;
  assign smpl_max   = res_max_q;
  assign smpl_sum   = res_sum_q;
  assign first_smpl = res_first_q;
  assign last_smpl  = res_last_q;
  assign ramp_err   = res_ramp_q;
  assign overrun    = res_ovr_q;

endmodule

// File: tb/tb_seq_burst_monitor.sv
// Bench for seq_burst_monitor: table of bursts with expected results fed through a
// scoreboard queue, plus random model-checked bursts and an async-reset abort sequence.
module tb_seq_burst_monitor;
  localparam int LEN_W = 11;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sequencing = 1'b0;
  logic [15:0]        smpl_in = '0;
  logic               busy, burst_done, ramp_err, overrun;
  logic [LEN_W-1:0]   burst_len;
  logic [15:0]        smpl_min, smpl_max, first_smpl, last_smpl;
  logic [16+LEN_W-1:0] smpl_sum;

  seq_burst_monitor #(.MAX_LEN(1024), .CHECK_RAMP(1'b1)) dut (
    .clk(clk), .rst(rst), .sequencing(sequencing), .smpl_in(smpl_in),
    .busy(busy), .burst_done(burst_done), .burst_len(burst_len),
    .smpl_min(smpl_min), .smpl_max(smpl_max), .smpl_sum(smpl_sum),
    .first_smpl(first_smpl), .last_smpl(last_smpl),
    .ramp_err(ramp_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     len;
    int     mn;
    int     mx;
    longint sum;
    int     first;
    int     last;
    int     ramp;
    int     ovr;
  } res_t;

  typedef struct {
    int   start;
    int   len;
    int   gidx;
    int   gval;
    int   gap;
    res_t exp;
  } vec_t;

  res_t sb[$];
  int   smp[$];
  vec_t tbl[7];
  res_t last_res;
  res_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference results computed straight from the sample list.
  function automatic res_t model();
    res_t r;
    r = '{0, 0, 0, 0, 0, 0, 0, 0};
    foreach (smp[i]) begin
      if (r.len == 1024) r.ovr = 1;
      else begin
        if (r.len == 0) begin
          r.mn = smp[i]; r.mx = smp[i]; r.first = smp[i];
        end else begin
          if (smp[i] != ((r.last + 1) & 32'hFFFF)) r.ramp = 1;
          if (smp[i] < r.mn) r.mn = smp[i];
          if (smp[i] > r.mx) r.mx = smp[i];
        end
        r.sum += longint'(smp[i]);
        r.last = smp[i];
        r.len++;
      end
    end
    return r;
  endfunction

  task automatic drive_burst(input res_t e, input int gap);
    for (int i = 0; i < smp.size(); i++) begin
      @(negedge clk);
      sequencing = 1'b1;
      smpl_in    = 16'(smp[i]);
    end
    @(negedge clk);
    chk("busy_in_burst", longint'(busy), 1);
    chk("done_low_in_burst", longint'(burst_done), 0);
    sequencing = 1'b0;
    smpl_in    = '0;
    sb.push_back(e);
    last_res = e;
    @(posedge clk);
    #1;
    chk("done_latency", longint'(burst_done), 1);
    chk("busy_report", longint'(busy), 0);
    repeat (gap) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (burst_done) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got burst_done=1 expected no pulse");
      end else begin
        mon_e = sb.pop_front();
        chk("len",   longint'(burst_len),  longint'(mon_e.len));
        chk("min",   longint'(smpl_min),   longint'(mon_e.mn));
        chk("max",   longint'(smpl_max),   longint'(mon_e.mx));
        chk("sum",   longint'(smpl_sum),   mon_e.sum);
        chk("first", longint'(first_smpl), longint'(mon_e.first));
        chk("last",  longint'(last_smpl),  longint'(mon_e.last));
        chk("ramp",  longint'(ramp_err),   longint'(mon_e.ramp));
        chk("ovr",   longint'(overrun),    longint'(mon_e.ovr));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int v, len, base;
    tbl[0] = '{512,   1021, -1, 0, 2, '{1021, 512, 1532, 1043462, 512, 1532, 0, 0}};
    tbl[1] = '{43981, 1,    -1, 0, 2, '{1, 43981, 43981, 43981, 43981, 43981, 0, 0}};
    tbl[2] = '{0,     100,  50, 7, 2, '{100, 0, 99, 4907, 0, 99, 1, 0}};
    tbl[3] = '{65534, 4,    -1, 0, 2, '{4, 0, 65535, 131070, 65534, 1, 0, 0}};
    tbl[4] = '{0,     1030, -1, 0, 2, '{1024, 0, 1023, 523776, 0, 1023, 0, 1}};
    tbl[5] = '{10,    10,   -1, 0, 0, '{10, 10, 19, 145, 10, 19, 0, 0}};
    tbl[6] = '{100,   5,    -1, 0, 2, '{5, 100, 104, 510, 100, 104, 0, 0}};

    repeat (3) @(negedge clk);
    chk("rst_len",        longint'(burst_len), 0);
    chk("rst_sum",        longint'(smpl_sum), 0);
    chk("rst_minmax",     longint'({smpl_min, smpl_max}), 0);
    chk("rst_firstlast",  longint'({first_smpl, last_smpl}), 0);
    chk("rst_flags",      longint'({ramp_err, overrun, busy, burst_done}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      smp.delete();
      for (int i = 0; i < tbl[k].len; i++) begin
        v = (tbl[k].start + i) & 32'hFFFF;
        if (i == tbl[k].gidx) v = tbl[k].gval;
        smp.push_back(v);
      end
      drive_burst(tbl[k].exp, tbl[k].gap);
    end

    for (int r = 0; r < 3; r++) begin
      smp.delete();
      len  = int'($urandom_range(1, 40));
      base = int'($urandom_range(0, 65535));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 65535));
        else v = (base + i) & 32'hFFFF;
        smp.push_back(v);
      end
      drive_burst(model(), 2);
    end

    // Abort a long ramp with an asynchronous reset partway through.
    for (int i = 0; i < 301; i++) begin
      @(negedge clk);
      if (i == 150) begin
        chk("hold_len_during_burst", longint'(burst_len), longint'(last_res.len));
        chk("hold_sum_during_burst", longint'(smpl_sum), last_res.sum);
      end
      sequencing = 1'b1;
      smpl_in    = 16'(i);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_len",       longint'(burst_len), 0);
    chk("abort_sum",       longint'(smpl_sum), 0);
    chk("abort_minmax",    longint'({smpl_min, smpl_max}), 0);
    chk("abort_firstlast", longint'({first_smpl, last_smpl}), 0);
    chk("abort_flags",     longint'({ramp_err, overrun, busy, burst_done}), 0);
    @(negedge clk);
    sequencing = 1'b0;
    smpl_in    = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    smp.delete();
    for (int i = 1; i <= 4; i++) smp.push_back(i);
    drive_burst('{4, 1, 4, 10, 1, 4, 0, 0}, 3);

    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
